serial_addsub_ctrl: RTL and testbench
=====================================

Name: serial_addsub_ctrl

Overview:
- Bit-serial adder/subtractor controller: sequences one shared 1-bit full_adder over WIDTH cycles to compute A+B or A−B (two's complement, B XOR mode, carry-in = mode).
- Replaces the WIDTH-wide ripple add/sub chain where area matters. Sits between a requester (start/operands) and consumers of result/flags.
- Single-operation-in-flight, start/done handshake.

Parameters:
- WIDTH, 4, operand/result width in bits (≥2).

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous active-low reset
- start  input  1  request; sampled only when ready=1
- mode  input  1  0 = add, 1 = subtract (A−B)
- a  input  WIDTH  operand A, captured with start
- b  input  WIDTH  operand B, captured with start
- ready  output  1  high in IDLE only
- busy  output  1  high in RUN and DONE (= ~ready)
- done  output  1  one-cycle pulse; result/flags valid
- result  output  WIDTH  sum/difference, held until next accepted start
- cout  output  1  final carry out (subtract: 1 = no borrow)
- overflow  output  1  signed overflow = carry into MSB XOR cout

Behaviour:
- Reset (rst_n=0 at clk edge, any state): state=IDLE, counter=0, carry=0, result=0, cout=0, overflow=0, done=0, ready=1, busy=0. Reset mid-operation aborts; there is no partial result and no done pulse.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - On start=1 at edge E0: latch a, b, mode into shift registers; carry<=mode; bit counter<=0; go RUN.
  - start=0: stay.
- RUN, one bit per cycle, LSB first:
  - Full_adder inputs: a_sh[0], b_sh[0]^mode_q, carry.
  - At each edge: sum bit shifts into result from MSB side (result <= {s, result[WIDTH-1:1]}). a_sh and b_sh shift right. carry<=fa_cout. counter++.
  - On the edge processing bit WIDTH-1, the incoming carry is saved as c_msb.
  - After WIDTH bit-edges (edge E0+WIDTH): cout<=fa_cout; overflow<=c_msb^fa_cout; go DONE.
- DONE:
  - done=1 for exactly this cycle (cycle after edge E0+WIDTH). Next edge: go IDLE.
  - Latency: start edge to done-high = WIDTH+1 cycles. Throughput: one operation per WIDTH+2 cycles.
- start while busy (RUN or DONE) is ignored: no queueing, and in-flight operands are unaffected. Operand/mode inputs change freely after the capture edge.
- result/cout/overflow are only meaningful from done onward. They are held until the next accepted start. During RUN, result holds partial shift contents, which are not defined for consumers.
- Counter width is clog2(WIDTH)+1. Terminal compare is counter==WIDTH-1; there is no wrap past it.
- All outputs are registered. ready and busy decode from state.

Decomposition:
- Package addsub_pkg:
  - state encoding (IDLE=2'd0, RUN=2'd1, DONE=2'd2)
  - MODE_ADD=1'b0, MODE_SUB=1'b1
- Sub-module: instantiate one existing full_adder (ports a, b, cin, s, cout) as the only arithmetic element. All sequencing stays in serial_addsub_ctrl.

Test Plan:
- Add, WIDTH=4: a=1011, b=1001, mode=0 → done 5 cycles after start edge; result=0100, cout=1, overflow=1 (−5 + −7).
- Subtract: a=1011, b=1001, mode=1 → result=0010, cout=1, overflow=0 (11−9=2).
- Subtract with borrow: a=0011, b=0101, mode=1 → result=1110, cout=0, overflow=0. Positive overflow: a=0111, b=0001, mode=0 → result=1000, cout=0, overflow=1.
- Busy ignore: start a=0001+b=0001. Pulse start with a=1111, b=1111 during RUN and during DONE → single done, result=0010; ready returns 1 one cycle after done.
- Reset mid-op: start, then rst_n=0 at 2nd RUN cycle → next cycle state IDLE, result=0, done never pulses. A new start after release completes normally.
- Back-to-back: assert start the first cycle ready=1 after a done → second done exactly WIDTH+2 cycles after the first.

Source files
------------

// File: rtl/addsub_pkg.sv
// Shared types and constants for the bit-serial add/subtract controller.
package addsub_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } state_e;

  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_SUB = 1'b1;

endpackage

// File: rtl/full_adder.sv
// Single-bit full adder; the only arithmetic element of the serial controller.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/serial_addsub_ctrl.sv
// Bit-serial A+B / A-B controller: one full_adder reused over WIDTH cycles, LSB first,
// with a start/done handshake and one operation in flight.
module serial_addsub_ctrl
  import addsub_pkg::*;
#(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             overflow
);

  localparam int unsigned CntW = $clog2(WIDTH) + 1;
  localparam logic [CntW-1:0] LastBit = CntW'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             mode_q, mode_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;
  logic             done_q, done_d;

  logic fa_s, fa_cout;

  full_adder u_full_adder (
    .a    (a_sh_q[0]),
    .b    (b_sh_q[0] ^ mode_q),
    .cin  (carry_q),
    .s    (fa_s),
    .cout (fa_cout)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    a_sh_d   = a_sh_q;
    b_sh_d   = b_sh_q;
    result_d = result_q;
    mode_d   = mode_q;
    carry_d  = carry_q;
    cout_d   = cout_q;
    ovf_d    = ovf_q;
    done_d   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          a_sh_d  = a;
          b_sh_d  = b;
          mode_d  = mode;
          carry_d = mode;
          cnt_d   = '0;
          state_d = StRun;
        end
      end
      StRun: begin
        result_d = {fa_s, result_q[WIDTH-1:1]};
        a_sh_d   = a_sh_q >> 1;
        b_sh_d   = b_sh_q >> 1;
        carry_d  = fa_cout;
        if (cnt_q == LastBit) begin
          // carry_q here is the carry into the MSB
          cout_d  = fa_cout;
          ovf_d   = carry_q ^ fa_cout;
          done_d  = 1'b1;
          state_d = StDone;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      result_q <= '0;
      mode_q   <= 1'b0;
      carry_q  <= 1'b0;
      cout_q   <= 1'b0;
      ovf_q    <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      a_sh_q   <= a_sh_d;
      b_sh_q   <= b_sh_d;
      result_q <= result_d;
      mode_q   <= mode_d;
      carry_q  <= carry_d;
      cout_q   <= cout_d;
      ovf_q    <= ovf_d;
      done_q   <= done_d;
    end
  end

  assign ready    = (state_q == StIdle);
  assign busy     = ~ready;
  assign done     = done_q;
  assign result   = result_q;
  assign cout     = cout_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_serial_addsub_ctrl.sv
// Self-checking bench for serial_addsub_ctrl: directed vectors, corner sequences and
// randomized operations against an arithmetic reference model.
module tb_serial_addsub_ctrl;
  import addsub_pkg::*;

  localparam int unsigned WIDTH = 4;
  localparam int unsigned Period = 10;

  logic             clk = 1'b0;
  logic             rst_n, start, mode;
  logic [WIDTH-1:0] a, b, result;
  logic             ready, busy, done, cout, overflow;

  int checks = 0;
  int errors = 0;

  always #(Period / 2) clk = ~clk;

  serial_addsub_ctrl #(.WIDTH(WIDTH)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .mode     (mode),
    .a        (a),
    .b        (b),
    .ready    (ready),
    .busy     (busy),
    .done     (done),
    .result   (result),
    .cout     (cout),
    .overflow (overflow)
  );

  typedef struct {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             m;
    logic [WIDTH-1:0] r;
    logic             co;
    logic             ov;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: plain integer arithmetic, returns {overflow, cout, result}
  function automatic logic [WIDTH+1:0] model(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                             input logic m);
    int ux, uy, sx, sy, full, sres;
    logic co, ov;
    logic [WIDTH-1:0] r;
    ux = int'(x);
    uy = int'(y);
    sx = (ux >= (1 << (WIDTH - 1))) ? ux - (1 << WIDTH) : ux;
    sy = (uy >= (1 << (WIDTH - 1))) ? uy - (1 << WIDTH) : uy;
    if (m == MODE_SUB) begin
      full = ux - uy;
      co   = (ux >= uy);
      sres = sx - sy;
    end else begin
      full = ux + uy;
      co   = (full >= (1 << WIDTH));
      sres = sx + sy;
    end
    r  = full[WIDTH-1:0];
    ov = (sres > (1 << (WIDTH - 1)) - 1) || (sres < -(1 << (WIDTH - 1)));
    return {ov, co, r};
  endfunction

  // Starts one operation on the next negedge; returns outputs at done and its latency
  task automatic run_op(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y, input logic m,
                        output logic [WIDTH-1:0] r, output logic co, output logic ov,
                        output int lat, output time t_done);
    @(negedge clk);
    a = x; b = y; mode = m; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    a = WIDTH'($urandom);
    b = WIDTH'($urandom);
    mode = 1'($urandom);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      if (lat == 2) begin
        check("ready_low_in_run", 32'(ready), 32'd0);
        check("busy_high_in_run", 32'(busy), 32'd1);
      end
    end while (!done && lat < 20);
    r = result; co = cout; ov = overflow; t_done = $time;
  endtask

  initial begin
    logic [WIDTH-1:0] r;
    logic [WIDTH+1:0] exp;
    logic co, ov;
    int lat, n_done, done_at;
    time t1, t2;

    vecs[0] = '{4'b1011, 4'b1001, MODE_ADD, 4'b0100, 1'b1, 1'b1};
    vecs[1] = '{4'b1011, 4'b1001, MODE_SUB, 4'b0010, 1'b1, 1'b0};
    vecs[2] = '{4'b0011, 4'b0101, MODE_SUB, 4'b1110, 1'b0, 1'b0};
    vecs[3] = '{4'b0111, 4'b0001, MODE_ADD, 4'b1000, 1'b0, 1'b1};
    vecs[4] = '{4'b0000, 4'b0000, MODE_SUB, 4'b0000, 1'b1, 1'b0};
    vecs[5] = '{4'b1000, 4'b0001, MODE_SUB, 4'b0111, 1'b1, 1'b1};

    rst_n = 1'b0; start = 1'b0; mode = 1'b0; a = '0; b = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_ready", 32'(ready), 32'd1);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_result", 32'(result), 32'd0);
    check("reset_cout", 32'(cout), 32'd0);
    check("reset_overflow", 32'(overflow), 32'd0);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      run_op(vecs[i].a, vecs[i].b, vecs[i].m, r, co, ov, lat, t1);
      check("vec_latency", 32'(lat), 32'(WIDTH + 1));
      check("vec_result", 32'(r), 32'(vecs[i].r));
      check("vec_cout", 32'(co), 32'(vecs[i].co));
      check("vec_overflow", 32'(ov), 32'(vecs[i].ov));
      @(negedge clk);
      check("vec_done_one_cycle", 32'(done), 32'd0);
      check("vec_ready_after_done", 32'(ready), 32'd1);
    end

    // Start pulses during RUN and DONE must be ignored
    @(negedge clk);
    a = 4'b0001; b = 4'b0001; mode = MODE_ADD; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    n_done = 0; done_at = -1; r = '0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done) begin
        n_done++;
        if (n_done == 1) begin
          done_at = i;
          r = result;
        end
      end
      if (i == WIDTH + 1) check("ignore_ready_back", 32'(ready), 32'd1);
      a = 4'hF; b = 4'hF; mode = MODE_ADD;
      start = (i == 1 || i == int'(WIDTH)) ? 1'b1 : 1'b0;
    end
    check("ignore_done_count", 32'(n_done), 32'd1);
    check("ignore_done_time", 32'(done_at), 32'(WIDTH));
    check("ignore_result", 32'(r), 32'h2);

    // Reset in the second RUN cycle aborts the operation
    @(negedge clk);
    a = 4'b0101; b = 4'b0011; mode = MODE_ADD; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    n_done = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (done) n_done++;
      if (i == 1) rst_n = 1'b0;
      if (i == 2) begin
        check("abort_ready", 32'(ready), 32'd1);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_result", 32'(result), 32'd0);
        rst_n = 1'b1;
      end
    end
    check("abort_no_done", 32'(n_done), 32'd0);
    run_op(4'b0101, 4'b0011, MODE_ADD, r, co, ov, lat, t1);
    check("after_abort_latency", 32'(lat), 32'(WIDTH + 1));
    check("after_abort_result", 32'(r), 32'h8);
    check("after_abort_overflow", 32'(ov), 32'd1);

    // Back-to-back: second start on the first ready cycle after done
    run_op(4'b0110, 4'b0011, MODE_SUB, r, co, ov, lat, t1);
    run_op(4'b0010, 4'b0111, MODE_SUB, r, co, ov, lat, t2);
    check("b2b_spacing", 32'((t2 - t1) / Period), 32'(WIDTH + 2));
    check("b2b_result", 32'(r), 32'hB);
    check("b2b_cout", 32'(co), 32'd0);

    for (int n = 0; n < 40; n++) begin
      logic [WIDTH-1:0] x, y;
      logic m;
      x = WIDTH'($urandom);
      y = WIDTH'($urandom);
      m = 1'($urandom);
      exp = model(x, y, m);
      run_op(x, y, m, r, co, ov, lat, t1);
      check("rand_latency", 32'(lat), 32'(WIDTH + 1));
      check("rand_result", 32'(r), 32'(exp[WIDTH-1:0]));
      check("rand_cout", 32'(co), 32'(exp[WIDTH]));
      check("rand_overflow", 32'(ov), 32'(exp[WIDTH+1]));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
